// File: rtl/inst_sram_pkg.sv
// Shared constants and types for the instruction-memory responder.
package inst_sram_pkg;

  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam int          INST_ADDR_WD = 10;

  // Source of the value presented on inst_sram_rdata.
  typedef enum logic [1:0] {
    RESP_ZERO,
    RESP_BANK,
    RESP_NOP
  } resp_sel_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } wait_state_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

endpackage

// File: rtl/sram_bank32.sv
// 2^ADDR_WD x 32 word array with byte-lane writes and a synchronous write-first read port.
module sram_bank32
  import inst_sram_pkg::*;
#(
  parameter int ADDR_WD = INST_ADDR_WD
) (
  input  logic               clk,
  input  logic               en,
  input  logic [3:0]         we,
  input  logic [ADDR_WD-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [0:(1<<ADDR_WD)-1];

  // Output register only loads on an access so the top can hold its response.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          rdata[8*i +: 8]     <= wdata[8*i +: 8];
        end else begin
          rdata[8*i +: 8]     <= mem[addr][8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/inst_sram.sv
// Instruction-memory responder: address decode, fault flagging and optional wait states.
// Define INST_SRAM_WAIT_EN to build the wait-state counter/FSM driving sram_stall.
module inst_sram
  import inst_sram_pkg::*;
#(
  parameter int          ADDR_WD     = INST_ADDR_WD,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        addr_err,
  output logic        sram_stall
);

  localparam logic [1:0] BASE_LO = BASE_ADDR[1:0];

  logic [31:0]        offset;
  logic [ADDR_WD-1:0] index;
  logic               in_range;
  logic               misaligned;
  logic               complete;
  logic               bank_en;
  logic [31:0]        bank_rdata;
  resp_sel_t          resp_sel_reg;

  assign offset     = inst_sram_addr - BASE_ADDR;
  assign index      = offset[ADDR_WD+1:2];
  assign in_range   = (offset[31:ADDR_WD+2] == '0);
  // Byte-offset bits plus base low bits reconstruct addr[1:0].
  assign misaligned = ((offset[1:0] + BASE_LO) != 2'b00);
  assign complete   = inst_sram_en & ~sram_stall;
  assign bank_en    = complete & in_range & resetn;

  sram_bank32 #(
    .ADDR_WD (ADDR_WD)
  ) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (inst_sram_we),
    .addr  (index),
    .wdata (inst_sram_wdata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_sel_reg <= RESP_ZERO;
      addr_err     <= 1'b0;
    end else begin
      addr_err <= complete & (~in_range | misaligned);
      if (complete) begin
        resp_sel_reg <= in_range ? RESP_BANK : RESP_NOP;
      end
    end
  end

  always_comb begin
    inst_sram_rdata = 32'h0000_0000;
    case (resp_sel_reg)
      RESP_BANK: inst_sram_rdata = bank_rdata;
      RESP_NOP:  inst_sram_rdata = INST_NOP;
      default:   inst_sram_rdata = 32'h0000_0000;
    endcase
  end

`ifdef INST_SRAM_WAIT_EN
  localparam int CNT_WD = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [CNT_WD-1:0] cnt_reg;
  wait_state_t       state_reg;

  // In IDLE the counter is zero, so only a non-zero wait count can stall.
  assign sram_stall = inst_sram_en &
                      ((state_reg == ST_IDLE) ? (WAIT_CYCLES != 0)
                                              : (cnt_reg < CNT_WD'(WAIT_CYCLES)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg   <= '0;
      state_reg <= ST_IDLE;
    end else if (inst_sram_en) begin
      if (sram_stall) begin
        cnt_reg   <= cnt_reg + 1'b1;
        state_reg <= ST_WAIT;
      end else begin
        cnt_reg   <= '0;
        state_reg <= ST_IDLE;
      end
    end
  end
`else
  assign sram_stall = 1'b0;
`endif

endmodule
